// File: rtl/pipe_hold_ctrl_if.sv
// Request/response bundle between the core pipeline and pipe_hold_ctrl:
// memory/redirect/hazard requests in, stage hold flags and PC redirect out.
interface pipe_hold_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req_i;
  logic              mem_ack_i;
  logic              jump_flag_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              load_use_i;

  logic [1:0]        pc_hold_o;
  logic [1:0]        if_id_hold_o;
  logic [1:0]        id_ex_hold_o;
  logic [1:0]        ex_memwb_hold_o;
  logic              jump_flag_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic              timeout_o;

  modport master (
    output mem_req_i, mem_ack_i, jump_flag_i, jump_addr_i, load_use_i,
    input  pc_hold_o, if_id_hold_o, id_ex_hold_o, ex_memwb_hold_o,
           jump_flag_o, jump_addr_o, timeout_o
  );

  modport slave (
    input  mem_req_i, mem_ack_i, jump_flag_i, jump_addr_i, load_use_i,
    output pc_hold_o, if_id_hold_o, id_ex_hold_o, ex_memwb_hold_o,
           jump_flag_o, jump_addr_o, timeout_o
  );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// Stall/flush controller for the 4-stage pipeline: memory wait, redirect bubble, load-use.
// Optional memory-wait abort is enabled by defining HOLD_TIMEOUT_EN.
module pipe_hold_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic            clk,
  input  logic            rst,
  pipe_hold_ctrl_if.slave bus
);

  localparam logic [1:0] HOLD_NONE  = 2'b00;
  localparam logic [1:0] HOLD_WAIT  = 2'b01;
  localparam logic [1:0] HOLD_FLUSH = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    FETCH_FLUSH
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       mem_stall;
  logic       timeout_hit;
  logic [1:0] pc_hold;
  logic [1:0] if_id_hold;
  logic [1:0] id_ex_hold;
  logic [1:0] ex_memwb_hold;
  logic       jump_flag;
  logic       timeout;

  if (TIMEOUT_CYCLES >= 2 ** CNT_W) begin : g_cfg_check
    $error("pipe_hold_ctrl: TIMEOUT_CYCLES must be below 2**CNT_W");
  end

  assign mem_stall = bus.mem_req_i & ~bus.mem_ack_i;

`ifdef HOLD_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  // The IDLE cycle that first sees the stall counts as wait cycle 1, so the
  // counter enters MEM_WAIT at 1 and reads N-1 on the N-th stalled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != MEM_WAIT) begin
      wait_cnt <= CNT_W'(1);
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (state == MEM_WAIT) && !bus.mem_ack_i &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_hold       = HOLD_NONE;
    if_id_hold    = HOLD_NONE;
    id_ex_hold    = HOLD_NONE;
    ex_memwb_hold = HOLD_NONE;
    jump_flag     = 1'b0;
    timeout       = 1'b0;

    unique case (state)
      IDLE: begin
        if (mem_stall)            state_nxt = MEM_WAIT;
        else if (bus.jump_flag_i) state_nxt = FETCH_FLUSH;
      end
      MEM_WAIT: begin
        if (bus.mem_ack_i || timeout_hit) state_nxt = IDLE;
      end
      FETCH_FLUSH: begin
        if (mem_stall)            state_nxt = MEM_WAIT;
        else if (bus.jump_flag_i) state_nxt = FETCH_FLUSH;
        else                      state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (rst) begin
      pc_hold       = HOLD_FLUSH;
      if_id_hold    = HOLD_FLUSH;
      id_ex_hold    = HOLD_FLUSH;
      ex_memwb_hold = HOLD_FLUSH;
    end else if (timeout_hit) begin
      ex_memwb_hold = HOLD_FLUSH;
      timeout       = 1'b1;
    end else if (mem_stall) begin
      pc_hold       = HOLD_WAIT;
      if_id_hold    = HOLD_WAIT;
      id_ex_hold    = HOLD_WAIT;
      ex_memwb_hold = HOLD_WAIT;
    end else if (bus.jump_flag_i) begin
      jump_flag     = 1'b1;
      if_id_hold    = HOLD_FLUSH;
      id_ex_hold    = HOLD_FLUSH;
    end else if (state == FETCH_FLUSH) begin
      if_id_hold    = HOLD_FLUSH;
    end else if (bus.load_use_i) begin
      pc_hold       = HOLD_WAIT;
      if_id_hold    = HOLD_WAIT;
      id_ex_hold    = HOLD_FLUSH;
    end
  end

  assign bus.pc_hold_o       = pc_hold;
  assign bus.if_id_hold_o    = if_id_hold;
  assign bus.id_ex_hold_o    = id_ex_hold;
  assign bus.ex_memwb_hold_o = ex_memwb_hold;
  assign bus.jump_flag_o     = jump_flag;
  assign bus.jump_addr_o     = jump_flag ? bus.jump_addr_i : '0;
  assign bus.timeout_o       = timeout;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed bench for pipe_hold_ctrl: event-level reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_pipe_hold_ctrl;

  localparam int unsigned TO_CYC = 4;
  localparam logic [1:0]  H_NONE  = 2'b00;
  localparam logic [1:0]  H_WAIT  = 2'b01;
  localparam logic [1:0]  H_FLUSH = 2'b10;
`ifdef HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Hold bundles packed as {pc, if_id, id_ex, ex_memwb}
  localparam logic [7:0] ALL_NONE  = 8'b00_00_00_00;
  localparam logic [7:0] ALL_WAIT  = 8'b01_01_01_01;
  localparam logic [7:0] ALL_FLUSH = 8'b10_10_10_10;
  localparam logic [7:0] JUMP_H    = 8'b00_10_10_00;
  localparam logic [7:0] BUBBLE_H  = 8'b00_10_00_00;
  localparam logic [7:0] LU_H      = 8'b01_01_10_00;
  localparam logic [7:0] TO_H      = 8'b00_00_00_10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hold_ctrl_if bus ();

  pipe_hold_ctrl #(
    .TIMEOUT_CYCLES(TO_CYC),
    .CNT_W         (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [7:0] dut_holds();
    return {bus.pc_hold_o, bus.if_id_hold_o, bus.id_ex_hold_o, bus.ex_memwb_hold_o};
  endfunction

  // Reference model history: access outstanding from an earlier cycle,
  // a redirect last cycle that still owes a fetch bubble, and stall run length.
  bit          m_wait   = 1'b0;
  bit          m_bubble = 1'b0;
  int unsigned m_run    = 0;

  always @(negedge clk) begin : model
    logic [7:0]  e_holds;
    logic        e_jf;
    logic        e_to;
    logic [31:0] e_ja;
    bit          stall;
    bit          tmo;
    int unsigned run;
    if (check_en) begin
      stall   = bus.mem_req_i && !bus.mem_ack_i;
      run     = m_wait ? m_run + 1 : (stall ? 1 : 0);
      tmo     = TO_EN && m_wait && !bus.mem_ack_i && (run == TO_CYC);
      e_holds = ALL_NONE;
      e_jf    = 1'b0;
      e_ja    = 32'h0;
      e_to    = 1'b0;
      if (rst)                  e_holds = ALL_FLUSH;
      else if (tmo)             begin e_holds = TO_H; e_to = 1'b1; end
      else if (stall)           e_holds = ALL_WAIT;
      else if (bus.jump_flag_i) begin e_holds = JUMP_H; e_jf = 1'b1; e_ja = bus.jump_addr_i; end
      else if (m_bubble)        e_holds = BUBBLE_H;
      else if (bus.load_use_i)  e_holds = LU_H;

      check("model pc_hold",       bus.pc_hold_o,       e_holds[7:6]);
      check("model if_id_hold",    bus.if_id_hold_o,    e_holds[5:4]);
      check("model id_ex_hold",    bus.id_ex_hold_o,    e_holds[3:2]);
      check("model ex_memwb_hold", bus.ex_memwb_hold_o, e_holds[1:0]);
      check("model jump_flag",     bus.jump_flag_o,     e_jf);
      check("model jump_addr",     bus.jump_addr_o,     e_ja);
      check("model timeout",       bus.timeout_o,       e_to);

      if (rst) begin
        m_wait   = 1'b0;
        m_bubble = 1'b0;
        m_run    = 0;
      end else begin
        m_bubble = !m_wait && !stall && bus.jump_flag_i;
        m_wait   = m_wait ? !(bus.mem_ack_i || tmo) : stall;
        m_run    = run;
      end
    end
  end

  task automatic cyc(input logic r, input logic req, input logic ack, input logic jmp,
                     input logic [31:0] addr, input logic lu);
    @(posedge clk);
    #1;
    rst             = r;
    bus.mem_req_i   = req;
    bus.mem_ack_i   = ack;
    bus.jump_flag_i = jmp;
    bus.jump_addr_i = addr;
    bus.load_use_i  = lu;
    #1;
  endtask

  task automatic lit(input string name, input logic [7:0] holds, input logic jf,
                     input logic [31:0] ja, input logic to);
    check($sformatf("%s holds", name),     dut_holds(),     holds);
    check($sformatf("%s jump_flag", name), bus.jump_flag_o, jf);
    check($sformatf("%s jump_addr", name), bus.jump_addr_o, ja);
    check($sformatf("%s timeout", name),   bus.timeout_o,   to);
  endtask

  initial begin
    bus.mem_req_i   = 1'b0;
    bus.mem_ack_i   = 1'b0;
    bus.jump_flag_i = 1'b0;
    bus.jump_addr_i = 32'h0;
    bus.load_use_i  = 1'b0;
    check_en        = 1'b1;

    cyc(1, 1, 0, 1, 32'h44, 1); lit("reset", ALL_FLUSH, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);  lit("idle", ALL_NONE, 0, 32'h0, 0);

    // Single redirect: flush now, if_id bubble next cycle, then clean
    cyc(0, 0, 0, 1, 32'h100, 0); lit("jump", JUMP_H, 1, 32'h100, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);   lit("jump bubble", BUBBLE_H, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);   lit("after bubble", ALL_NONE, 0, 32'h0, 0);

    // Back-to-back redirects re-enter the bubble
    cyc(0, 0, 0, 1, 32'h200, 0);
    cyc(0, 0, 0, 1, 32'h300, 0); lit("jump in bubble", JUMP_H, 1, 32'h300, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);   lit("second bubble", BUBBLE_H, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);

    // Load-use alone, then load-use with a jump
    cyc(0, 0, 0, 0, 32'h0, 1);   lit("load_use", LU_H, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 1, 32'h400, 1); lit("lu+jump", JUMP_H, 1, 32'h400, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);

    // 3-cycle memory access
    cyc(0, 1, 0, 0, 32'h0, 0);   lit("mem w1", ALL_WAIT, 0, 32'h0, 0);
    cyc(0, 1, 0, 0, 32'h0, 0);   lit("mem w2", ALL_WAIT, 0, 32'h0, 0);
    cyc(0, 1, 1, 0, 32'h0, 0);   lit("mem ack", ALL_NONE, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);

    // Zero-wait access leaves the FSM idle
    cyc(0, 1, 1, 0, 32'h0, 0);   lit("zero wait", ALL_NONE, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 1);   lit("after zero wait", LU_H, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);

    // Jump held during a wait redirects only on the ack cycle
    cyc(0, 1, 0, 1, 32'h500, 0); lit("jump in wait", ALL_WAIT, 0, 32'h0, 0);
    cyc(0, 1, 0, 1, 32'h500, 0); lit("jump in wait 2", ALL_WAIT, 0, 32'h0, 0);
    cyc(0, 1, 1, 1, 32'h500, 0); lit("jump at ack", JUMP_H, 1, 32'h500, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);

    // Reset on wait cycle 3 abandons the access
    cyc(0, 1, 0, 0, 32'h0, 0);
    cyc(0, 1, 0, 0, 32'h0, 0);
    cyc(1, 1, 0, 0, 32'h0, 0);   lit("reset in wait", ALL_FLUSH, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);   lit("after reset", ALL_NONE, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 1);   lit("idle after reset", LU_H, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);

    // Memory that never acks
`ifdef HOLD_TIMEOUT_EN
    for (int i = 1; i < int'(TO_CYC); i++) begin
      cyc(0, 1, 0, 0, 32'h0, 0); lit($sformatf("long wait %0d", i), ALL_WAIT, 0, 32'h0, 0);
    end
    cyc(0, 1, 0, 0, 32'h0, 0);   lit("timeout", TO_H, 0, 32'h0, 1);
    cyc(0, 0, 0, 0, 32'h0, 0);   lit("after timeout", ALL_NONE, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 1);   lit("idle after timeout", LU_H, 0, 32'h0, 0);
`else
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 0, 0, 32'h0, 0); lit($sformatf("long wait %0d", i), ALL_WAIT, 0, 32'h0, 0);
    end
    cyc(0, 1, 1, 0, 32'h0, 0);   lit("long wait ack", ALL_NONE, 0, 32'h0, 0);
`endif
    cyc(0, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);

    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
